qmult_rr_sched: RTL

//   Shares one signed fixed-point (Q-format, sign-magnitude core) multiplier among NUM_REQ requesters.

---
 rtl/qmult_rr_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/qmult_rr_sched.sv
// Round-robin shared Q-format multiplier; each result is tagged with the id of the requester that supplied it.
// Accept -> res_valid after two edges; res_valid & !res_ready freezes both stages and withholds all grants.
module qmult_rr_sched #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int N        = 16,
    parameter int Q        = 12,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*N-1:0]   req_a,
    input  logic [NUM_REQ*N-1:0]   req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [N-1:0]           res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_ovf,
    output logic [CNT_W-1:0]       ovf_cnt
);

    logic              adv;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_vld, gnt_ok;

    logic              s1_vld_q, s1_vld_d;
    logic [N-1:0]      s1_a_q, s1_a_d;
    logic [N-1:0]      s1_b_q, s1_b_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;

    logic              res_valid_q;
    logic [N-1:0]      res_data_q;
    logic [ID_W-1:0]   res_id_q;
    logic              res_ovf_q;
    logic [CNT_W-1:0]  ovf_cnt_q;

    logic [N-2:0]      ma, mb, m_raw, m_fin;
    logic [2*N-3:0]    prod;
    logic              ovf, sgn;
    logic [N-1:0]      prod_data;

    // The most negative code has no positive twin; it is treated as the largest magnitude.
    function automatic logic [N-2:0] magnitude(input logic [N-1:0] x);
        if (!x[N-1])
            return x[N-2:0];
        else if (x[N-2:0] == '0)
            return '1;
        else
            return (N-1)'(-x);
    endfunction

    assign adv = !res_valid_q || res_ready;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_vld && req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    assign gnt_ok = gnt_vld && adv && !rst;

    always_comb begin
        req_ready = '0;
        ptr_d     = ptr_q;
        if (gnt_ok) begin
            req_ready[gnt_id] = 1'b1;
            ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_id_d  = s1_id_q;
        if (adv) begin
            s1_vld_d = gnt_ok;
            s1_a_d   = req_a[gnt_id*N +: N];
            s1_b_d   = req_b[gnt_id*N +: N];
            s1_id_d  = gnt_id;
        end
    end

    always_comb begin
        ma        = magnitude(s1_a_q);
        mb        = magnitude(s1_b_q);
        prod      = {{(N-1){1'b0}}, ma} * {{(N-1){1'b0}}, mb};
        ovf       = (prod >> (N - 1 + Q)) != '0;
        m_raw     = (N-1)'(prod >> Q);
        m_fin     = (ovf && SATURATE != 0) ? '1 : m_raw;
        sgn       = s1_a_q[N-1] ^ s1_b_q[N-1];
        prod_data = (sgn && m_fin != '0) ? -{1'b0, m_fin} : {1'b0, m_fin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_id_q  <= s1_id_d;
            if (adv) begin
                res_valid_q <= s1_vld_q;
                res_data_q  <= prod_data;
                res_id_q    <= s1_id_q;
                res_ovf_q   <= ovf;
            end
        end
    end

    // Counts delivered overflows only, and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_cnt_q <= '0;
        else if (res_valid_q && res_ready && res_ovf_q && ovf_cnt_q != '1)
            ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_ovf   = res_ovf_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule
